// File: rtl/eer_pkg.sv
// Shared constants and types for the EER-RL node blocks: packet types, divide FSM states and
// per-packet energy costs.
package eer_pkg;

  localparam logic [2:0] PKT_HB   = 3'b000;
  localparam logic [2:0] PKT_CHE  = 3'b001;
  localparam logic [2:0] PKT_INV  = 3'b010;
  localparam logic [2:0] PKT_CHTS = 3'b100;
  localparam logic [2:0] PKT_DATA = 3'b101;

  localparam logic [15:0] RX_PKT_NRG = 16'h0004;
  localparam logic [15:0] HOP1_TX    = 16'h0005;
  localparam logic [15:0] HOP4_TX    = 16'h001b;

  typedef enum logic [1:0] {
    StIdle,
    StDiv,
    StDone
  } node_state_e;

endpackage

// File: rtl/seq_divider.sv
// Unsigned restoring divider producing one quotient bit per clock, MSB first.
// done is high during the cycle that computes the final quotient bit.
module seq_divider #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  logic [WIDTH:0]   rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;
  logic [CntW-1:0]  cnt_q;

  logic [WIDTH:0] rem_shift;
  logic [WIDTH:0] rem_next;
  logic           fits;

  always_comb begin
    rem_shift = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    fits      = rem_shift >= {1'b0, dvs_q};
    rem_next  = fits ? (rem_shift - {1'b0, dvs_q}) : rem_shift;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else if (start) begin
      rem_q <= '0;
      quo_q <= dividend;
      dvs_q <= divisor;
      cnt_q <= CntW'(WIDTH);
    end else if (cnt_q != '0) begin
      rem_q <= rem_next;
      quo_q <= {quo_q[WIDTH-2:0], fits};
      cnt_q <= cnt_q - CntW'(1);
    end
  end

  assign busy     = (cnt_q != '0);
  assign done     = (cnt_q == CntW'(1));
  assign quotient = quo_q;

endmodule

// File: rtl/node_info_param.sv
// Node-state block: decodes parsed packet fields into hop distance, Q-value, cluster role,
// TDMA timeslot and a hysteretic low-energy flag.
module node_info_param
  import eer_pkg::*;
#(
  parameter int unsigned      WIDTH              = 16,
  parameter logic [WIDTH-1:0] NODE_ID            = 16'h000C,
  parameter logic [WIDTH-1:0] E_HYST             = 16'h0010,
  parameter bit               ACCEPT_BETTER_HOPS = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_MNI,
  input  logic [2:0]       fPktType,
  input  logic [WIDTH-1:0] energy,
  input  logic [WIDTH-1:0] e_threshold,
  input  logic [WIDTH-1:0] destinationID,
  input  logic [WIDTH-1:0] hops,
  input  logic [WIDTH-1:0] timeslot,
  input  logic             round_start,
  output logic [WIDTH-1:0] myNodeID,
  output logic [WIDTH-1:0] hopsFromSink,
  output logic [WIDTH-1:0] myQValue,
  output logic             q_valid,
  output logic             busy,
  output logic             role,
  output logic [WIDTH-1:0] myTimeslot,
  output logic             ts_valid,
  output logic             low_E
);

  node_state_e state_q, state_d;

  logic             hb_lock;
  logic             act;
  logic             for_me;
  logic             hb_accept;
  logic [WIDTH-1:0] divisor;
  logic             div_busy;
  logic             div_done;
  logic [WIDTH-1:0] div_quotient;
  logic [WIDTH:0]   hyst_sum;
  logic [WIDTH-1:0] clear_level;

  assign busy   = (state_q != StIdle);
  assign act    = en_MNI && !busy && !round_start;
  assign for_me = (destinationID == NODE_ID);

  assign hb_accept = act && (fPktType == PKT_HB) && (hops != '1) &&
                     (!hb_lock || (ACCEPT_BETTER_HOPS && (hops < hopsFromSink)));

  // Zero hops means "at the sink"; treat as one hop so the divide is defined.
  assign divisor = (hops == '0) ? WIDTH'(1) : hops;

  // Saturate so a threshold near full scale cannot wrap to a tiny clear level.
  assign hyst_sum    = {1'b0, e_threshold} + {1'b0, E_HYST};
  assign clear_level = hyst_sum[WIDTH] ? '1 : hyst_sum[WIDTH-1:0];

  seq_divider #(
    .WIDTH(WIDTH)
  ) u_div (
    .clk     (clk),
    .rst     (rst),
    .start   (hb_accept),
    .dividend(energy),
    .divisor (divisor),
    .busy    (div_busy),
    .done    (div_done),
    .quotient(div_quotient)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (hb_accept) state_d = StDiv;
      StDiv:   if (div_done || !div_busy) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hopsFromSink <= '1;
      myQValue     <= '0;
      q_valid      <= 1'b0;
      role         <= 1'b0;
      myTimeslot   <= '0;
      ts_valid     <= 1'b0;
      hb_lock      <= 1'b0;
      low_E        <= 1'b0;
    end else begin
      if (energy < e_threshold) begin
        low_E <= 1'b1;
      end else if (energy >= clear_level) begin
        low_E <= 1'b0;
      end

      if (state_q == StDone) begin
        myQValue <= div_quotient;
        q_valid  <= 1'b1;
      end

      if (round_start) begin
        role     <= 1'b0;
        ts_valid <= 1'b0;
        hb_lock  <= 1'b0;
      end

      if (hb_accept) begin
        hopsFromSink <= hops;
        hb_lock      <= 1'b1;
        q_valid      <= 1'b0;
      end

      if (act) begin
        if (fPktType == PKT_CHE && for_me) begin
          role <= 1'b1;
        end
        if (fPktType == PKT_CHTS && for_me && !role) begin
          myTimeslot <= timeslot;
          ts_valid   <= 1'b1;
        end
        if (fPktType == PKT_DATA) begin
          hb_lock <= 1'b0;
        end
      end
    end
  end

  assign myNodeID = NODE_ID;

endmodule

// File: tb/tb_node_info_param.sv
// Directed plan followed by random packet traffic, every cycle compared against a
// transaction-level model of the node state.
module tb_node_info_param;

  localparam int unsigned W       = 16;
  localparam logic [15:0] ID      = 16'h000C;
  localparam int          HYST    = 16;
  localparam int          LATENCY = W + 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        en_MNI;
  logic [2:0]  fPktType;
  logic [15:0] energy;
  logic [15:0] e_threshold;
  logic [15:0] destinationID;
  logic [15:0] hops;
  logic [15:0] timeslot;
  logic        round_start;
  logic [15:0] myNodeID;
  logic [15:0] hopsFromSink;
  logic [15:0] myQValue;
  logic        q_valid;
  logic        busy;
  logic        role;
  logic [15:0] myTimeslot;
  logic        ts_valid;
  logic        low_E;

  node_info_param dut (
    .clk          (clk),
    .rst          (rst),
    .en_MNI       (en_MNI),
    .fPktType     (fPktType),
    .energy       (energy),
    .e_threshold  (e_threshold),
    .destinationID(destinationID),
    .hops         (hops),
    .timeslot     (timeslot),
    .round_start  (round_start),
    .myNodeID     (myNodeID),
    .hopsFromSink (hopsFromSink),
    .myQValue     (myQValue),
    .q_valid      (q_valid),
    .busy         (busy),
    .role         (role),
    .myTimeslot   (myTimeslot),
    .ts_valid     (ts_valid),
    .low_E        (low_E)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference state: the divide is modelled only as a countdown to a precomputed quotient.
  logic [15:0] m_hops, m_q, m_pend, m_ts;
  logic        m_qv, m_role, m_tsv, m_lock, m_lowe;
  int          m_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_update();
    int  sat;
    bit  act;
    if (rst) begin
      m_hops = 16'hFFFF; m_q = '0; m_pend = '0; m_ts = '0;
      m_qv = 0; m_role = 0; m_tsv = 0; m_lock = 0; m_lowe = 0; m_cnt = 0;
    end else begin
      sat = int'(e_threshold) + HYST;
      if (sat > 65535) sat = 65535;
      if (energy < e_threshold) m_lowe = 1;
      else if (int'(energy) >= sat) m_lowe = 0;

      act = en_MNI && (m_cnt == 0) && !round_start;
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_q  = m_pend;
          m_qv = 1;
        end
      end
      if (round_start) begin
        m_role = 0; m_tsv = 0; m_lock = 0;
      end
      if (act) begin
        case (fPktType)
          3'b000: if (hops != 16'hFFFF && (!m_lock || hops < m_hops)) begin
            m_hops = hops;
            m_pend = 16'(int'(energy) / ((hops == 0) ? 1 : int'(hops)));
            m_lock = 1;
            m_qv   = 0;
            m_cnt  = LATENCY;
          end
          3'b001: if (destinationID == ID) m_role = 1;
          3'b100: if (destinationID == ID && !m_role) begin
            m_ts  = timeslot;
            m_tsv = 1;
          end
          3'b101: m_lock = 0;
          default: ;
        endcase
      end
    end
  endtask

  task automatic compare_all();
    check("myNodeID", 32'(myNodeID), 32'(ID));
    check("hopsFromSink", 32'(hopsFromSink), 32'(m_hops));
    check("myQValue", 32'(myQValue), 32'(m_q));
    check("q_valid", 32'(q_valid), 32'(m_qv));
    check("busy", 32'(busy), 32'(m_cnt > 0));
    check("role", 32'(role), 32'(m_role));
    check("myTimeslot", 32'(myTimeslot), 32'(m_ts));
    check("ts_valid", 32'(ts_valid), 32'(m_tsv));
    check("low_E", 32'(low_E), 32'(m_lowe));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_update();
    #1;
    compare_all();
  endtask

  task automatic quiet();
    rst = 0; en_MNI = 0; round_start = 0;
  endtask

  task automatic pkt(input logic [2:0] t, input logic [15:0] d, input logic [15:0] h,
                     input logic [15:0] ts);
    en_MNI = 1; fPktType = t; destinationID = d; hops = h; timeslot = ts;
    cyc();
    en_MNI = 0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  int busy_cycles;
  int qv_edge;

  initial begin
    rst = 1; en_MNI = 0; round_start = 0; fPktType = 3'b010;
    energy = 16'h7FF8; e_threshold = 16'h0000; destinationID = '0; hops = '0; timeslot = '0;
    cyc();
    check("reset_hops", 32'(hopsFromSink), 32'hFFFF);
    quiet();
    cyc();

    // First heartbeat: busy window and q_valid latency.
    energy = 16'h7FF8;
    pkt(3'b000, 16'h0000, 16'd3, 16'd0);
    busy_cycles = busy ? 1 : 0;
    qv_edge = 0;
    for (int i = 1; i <= 20; i++) begin
      cyc();
      if (busy) busy_cycles++;
      if (q_valid && qv_edge == 0) qv_edge = i;
    end
    check("busy_len", 32'(busy_cycles), 32'd17);
    check("qv_latency", 32'(qv_edge), 32'd17);
    check("q_hops3", 32'(myQValue), 32'h2AA8);

    energy = 16'h7FF4;
    pkt(3'b000, 16'h0000, 16'd2, 16'd0);
    run(18);
    check("q_hops2", 32'(myQValue), 32'h3FFA);
    pkt(3'b000, 16'h0000, 16'd4, 16'd0);
    check("worse_hops_dropped", 32'(hopsFromSink), 32'd2);
    run(2);
    pkt(3'b101, 16'h0000, 16'd0, 16'd0);
    pkt(3'b000, 16'h0000, 16'd4, 16'd0);
    run(18);
    check("relock_hops4", 32'(hopsFromSink), 32'd4);

    // Role and timeslot.
    pkt(3'b001, 16'd32, 16'd0, 16'd0);
    check("che_other", 32'(role), 32'd0);
    pkt(3'b100, ID, 16'd0, 16'd5);
    check("chts_ts", 32'(myTimeslot), 32'd5);
    check("chts_valid", 32'(ts_valid), 32'd1);
    pkt(3'b001, ID, 16'd0, 16'd0);
    check("che_me", 32'(role), 32'd1);
    pkt(3'b100, ID, 16'd0, 16'd7);
    check("chts_as_ch", 32'(myTimeslot), 32'd5);
    round_start = 1; cyc(); round_start = 0;
    check("rs_role", 32'(role), 32'd0);
    check("rs_tsv", 32'(ts_valid), 32'd0);

    // Hysteresis.
    e_threshold = 16'h3333;
    energy = 16'h3334; cyc(); check("lowe_3334", 32'(low_E), 32'd0);
    energy = 16'h3332; cyc(); check("lowe_3332", 32'(low_E), 32'd1);
    energy = 16'h3340; cyc(); check("lowe_3340", 32'(low_E), 32'd1);
    energy = 16'h3343; cyc(); check("lowe_3343", 32'(low_E), 32'd0);
    e_threshold = 16'hFFF8;
    energy = 16'h1000; cyc(); check("lowe_sat_set", 32'(low_E), 32'd1);
    energy = 16'hFFF9; cyc(); check("lowe_sat_hold", 32'(low_E), 32'd1);
    energy = 16'hFFFF; cyc(); check("lowe_sat_clr", 32'(low_E), 32'd0);
    e_threshold = 16'h0000;

    // Drops: packet while busy, and round_start beating a heartbeat.
    energy = 16'h1234;
    pkt(3'b000, 16'h0000, 16'd1, 16'd0);
    pkt(3'b001, ID, 16'd0, 16'd0);
    check("che_busy_drop", 32'(role), 32'd0);
    run(18);
    pkt(3'b101, 16'h0000, 16'd0, 16'd0);
    round_start = 1;
    pkt(3'b000, 16'h0000, 16'd1, 16'd0);
    round_start = 0;
    check("rs_beats_hb", 32'(busy), 32'd0);

    // Reset mid-divide, all-ones hops, zero hops.
    pkt(3'b000, 16'h0000, 16'd0, 16'd0);
    run(7);
    rst = 1; cyc(); rst = 0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_qv", 32'(q_valid), 32'd0);
    check("rst_hops", 32'(hopsFromSink), 32'hFFFF);
    pkt(3'b000, 16'h0000, 16'hFFFF, 16'd0);
    check("hops_ones_ignored", 32'(busy), 32'd0);
    energy = 16'h4000;
    pkt(3'b000, 16'h0000, 16'd0, 16'd0);
    run(18);
    check("q_hops0", 32'(myQValue), 32'h4000);

    // Random traffic.
    for (int i = 0; i < 2500; i++) begin
      rst         = ($urandom_range(0, 499) == 0);
      round_start = ($urandom_range(0, 39) == 0);
      en_MNI      = ($urandom_range(0, 2) == 0);
      fPktType    = 3'($urandom_range(0, 7));
      destinationID = ($urandom_range(0, 1) == 1) ? ID : 16'($urandom);
      hops        = ($urandom_range(0, 9) == 0) ? 16'hFFFF : 16'($urandom_range(0, 12));
      timeslot    = 16'($urandom);
      if ($urandom_range(0, 49) == 0) e_threshold = 16'($urandom);
      energy      = ($urandom_range(0, 3) == 0) ? 16'($urandom)
                                                : 16'(e_threshold + 16'($urandom_range(0, 40)) - 16'd20);
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/node_info_param.md
Name: node_info_param

Overview:
- Parametrised next-generation node-state block for the EER-RL clustered WSN node.
- Decodes received packet fields (heartbeat, CH election, CH timeslot, data) and maintains:
  - hop distance to sink
  - Q-value (energy / hops), computed by a sequential divider
  - cluster role and assigned TDMA timeslot
  - low-energy flag with hysteresis
- Sits between the packet parser and the routing/MAC controller.

Parameters:
- WIDTH, 16, width of energy/ID/hops/timeslot/Q words (energy in 2.(WIDTH-2) fixed point)
- NODE_ID, 16'h000C, this node's ID
- E_HYST, 16'h0010, hysteresis added to e_threshold before low_E clears
- ACCEPT_BETTER_HOPS, 1, 1 = locked node still accepts a heartbeat with strictly fewer hops

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous active-high reset
- en_MNI  in  1  one-cycle strobe: packet fields valid
- fPktType  in  3  000 HB, 001 CHE, 010 INV, 100 CHTS, 101 DATA, others ignored
- energy  in  WIDTH  current residual energy
- e_threshold  in  WIDTH  low-energy threshold
- destinationID  in  WIDTH  packet destination ID
- hops  in  WIDTH  hop count carried in packet
- timeslot  in  WIDTH  timeslot carried in CHTS packet
- round_start  in  1  one-cycle strobe: new clustering round
- myNodeID  out  WIDTH  constant NODE_ID
- hopsFromSink  out  WIDTH  accepted hop count
- myQValue  out  WIDTH  energy_latched / max(hopsFromSink,1)
- q_valid  out  1  myQValue is current
- busy  out  1  divider running; en_MNI ignored
- role  out  1  1 = cluster head
- myTimeslot  out  WIDTH  assigned member timeslot
- ts_valid  out  1  myTimeslot is assigned
- low_E  out  1  energy below threshold (hysteretic)

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values:
  - hopsFromSink = all-ones (unknown)
  - myQValue, myTimeslot = 0
  - q_valid, ts_valid, role, low_E, busy, internal hb_lock = 0
- FSM states:
  - IDLE → DIV on an accepted HB.
  - DIV runs exactly WIDTH cycles, then → DONE.
  - DONE lasts one cycle: writes myQValue, sets q_valid, → IDLE.
- busy = 1 in DIV and DONE.
- Latency: q_valid rises WIDTH+1 clocks after the edge that samples the HB strobe.
- Packets are acted on only when en_MNI=1, busy=0, round_start=0; otherwise dropped silently, with no state change.
- HB is accepted when:
  - hops != all-ones, and
  - hb_lock=0, or (ACCEPT_BETTER_HOPS=1 and hops < hopsFromSink).
- On HB accept:
  - hopsFromSink ← hops; energy is latched; hb_lock ← 1.
  - q_valid ← 0; divide starts.
  - hops=0 divides by 1.
- CHE: destinationID == NODE_ID sets role=1; a mismatch leaves role unchanged.
- CHTS:
  - If role=0 and destinationID == NODE_ID: myTimeslot ← timeslot, ts_valid ← 1.
  - Ignored when role=1.
- DATA: hb_lock ← 0.
- INV and undefined types: no effect.
- round_start:
  - role ← 0, ts_valid ← 0, hb_lock ← 0.
  - Beats a same-cycle en_MNI (the packet is dropped).
  - Does not abort a running divide; hopsFromSink and myQValue are kept.
- low_E, evaluated every cycle independent of en_MNI:
  - Set when energy < e_threshold.
  - Cleared when energy ≥ e_threshold + E_HYST; the sum is computed in WIDTH+1 bits, saturating at all-ones.
  - Otherwise held.
- Divider: unsigned restoring, one quotient bit per cycle, MSB first; quotient truncated.
- rst mid-divide aborts immediately to reset values.

Decomposition:
- Shared package eer_pkg holds:
  - packet-type constants (PKT_HB=3'b000, PKT_CHE=3'b001, PKT_INV=3'b010, PKT_CHTS=3'b100, PKT_DATA=3'b101)
  - FSM state typedef
  - energy constants RX_PKT_NRG=16'h0004, HOP1_TX=16'h0005, HOP4_TX=16'h001b
- One sub-module: seq_divider, parametrised by WIDTH.
  - Ports: start, dividend, divisor, busy, done, quotient.
  - Reused later by the reward unit.

Test Plan:
- Reset, then HB hops=3, energy=0x7FF8 → hopsFromSink=3, busy high 17 cycles, myQValue=0x2AA8, q_valid at cycle 17.
- HB path updates:
  - Then HB hops=2, energy=0x7FF4 → accepted, myQValue=0x3FFA.
  - Then HB hops=4 → dropped; values unchanged.
  - Then DATA, then HB hops=4 → accepted, hopsFromSink=4.
- Role and timeslot:
  - CHE dest=32 → role stays 0.
  - CHTS dest=0x000C, ts=5 → myTimeslot=5, ts_valid=1.
  - CHE dest=0x000C → role=1 next cycle.
  - Later CHTS ts=7 ignored.
  - round_start → role=0, ts_valid=0.
- low_E with e_threshold=0x3333, E_HYST=0x0010:
  - energy 0x3334 → 0.
  - 0x3332 → 1.
  - 0x3340 → stays 1.
  - 0x3343 → 0.
  - Threshold 0xFFF8 → sum saturates, no wrap.
- Drop and priority cases:
  - CHE dest=0x000C strobed while busy → dropped, role=0.
  - round_start with a same-cycle HB → HB dropped.
- Reset and corner cases:
  - rst asserted at divide cycle 8 → busy=0, q_valid=0, hopsFromSink=0xFFFF next cycle.
  - HB hops=0xFFFF → ignored.
  - HB hops=0, energy=0x4000 → myQValue=0x4000.
